// File: rtl/kf_host_ctrl.sv
// Host-side initiator for the Kalman filter ASIC port: loads a frame, pulses START, captures DATA_OUT.
// Define KF_HOST_TIMEOUT_EN to build the wait-state timeout counter driven by timeout_limit.
module kf_host_ctrl #(
  parameter int W         = 24,
  parameter int ADDRW     = 5,
  parameter int NLOAD     = 4,
  parameter int LOAD_BASE = 0,
  parameter int TO_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_timeout,
  input  logic [TO_W-1:0]  timeout_limit,
  output logic             kf_START,
  output logic [W-1:0]     kf_DATA_IN,
  output logic [ADDRW-1:0] kf_DIR,
  output logic             kf_WRITE,
  input  logic             kf_READY,
  input  logic [W-1:0]     kf_DATA_OUT,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KICK, S_WAIT_BUSY, S_WAIT_DONE, S_OUT
  } state_e;

  localparam logic [ADDRW:0]   LAST_IDX = (ADDRW+1)'(NLOAD - 1);
  localparam logic [ADDRW-1:0] BASE     = ADDRW'(LOAD_BASE);

  state_e           state_q, state_d;
  logic [ADDRW:0]   idx_q, idx_d;
  logic             write_q, write_d;
  logic             start_q, start_d;
  logic [W-1:0]     data_in_q, data_in_d;
  logic [ADDRW-1:0] dir_q, dir_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             accept, go_done, go_timeout, timeout_hit;

  assign accept   = in_valid && (state_q == S_LOAD);
  assign go_done  = (state_q == S_WAIT_DONE) && kf_READY;
  // A timeout only wins when the normal exit of that wait state is not taken in the same cycle.
  assign go_timeout = timeout_hit &&
                      (((state_q == S_WAIT_BUSY) && kf_READY) ||
                       ((state_q == S_WAIT_DONE) && !kf_READY));

`ifdef KF_HOST_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic            out_timeout_q;

  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + TO_W'(1);
  assign timeout_hit = (timeout_limit != '0) && (cnt_inc == timeout_limit);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_KICK) begin
      cnt_d = '0;
    end else if ((state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE)) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      out_timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (go_done) begin
        out_timeout_q <= 1'b0;
      end else if (go_timeout) begin
        out_timeout_q <= 1'b1;
      end
    end
  end

  assign out_timeout = out_timeout_q;
`else
  logic unused_timeout_limit;
  assign unused_timeout_limit = ^timeout_limit;
  assign timeout_hit          = 1'b0;
  assign out_timeout          = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    write_d     = 1'b0;
    start_d     = 1'b0;
    data_in_d   = data_in_q;
    dir_d       = dir_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (kf_READY) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (accept) begin
          write_d   = 1'b1;
          data_in_d = in_data;
          dir_d     = BASE + idx_q[ADDRW-1:0];
          idx_d     = idx_q + (ADDRW+1)'(1);
          if (idx_q == LAST_IDX) state_d = S_KICK;
        end
      end
      S_KICK: begin
        start_d = 1'b1;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!kf_READY) begin
          state_d = S_WAIT_DONE;
        end else if (go_timeout) begin
          state_d     = S_OUT;
          out_valid_d = 1'b1;
          out_data_d  = '0;
        end
      end
      S_WAIT_DONE: begin
        if (go_done) begin
          state_d     = S_OUT;
          out_valid_d = 1'b1;
          out_data_d  = kf_DATA_OUT;
        end else if (go_timeout) begin
          state_d     = S_OUT;
          out_valid_d = 1'b1;
          out_data_d  = '0;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      write_q     <= 1'b0;
      start_q     <= 1'b0;
      data_in_q   <= '0;
      dir_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      start_q     <= start_d;
      data_in_q   <= data_in_d;
      dir_q       <= dir_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign kf_WRITE   = write_q;
  assign kf_START   = start_q;
  assign kf_DATA_IN = data_in_q;
  assign kf_DIR     = dir_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

endmodule

// File: tb/tb_kf_host_ctrl.sv
// Self-checking bench for kf_host_ctrl: two instances (LOAD_BASE 0 and 30) share one stimulus stream.
module tb_kf_host_ctrl;
  localparam int W = 24, ADDRW = 5, NLOAD = 4, TO_W = 16;
  localparam int BASE_A = 0, BASE_B = 30;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, kf_READY;
  logic [W-1:0] in_data, kf_DATA_OUT;
  logic [TO_W-1:0] timeout_limit;

  logic in_ready_a, out_valid_a, out_timeout_a, kf_START_a, kf_WRITE_a, busy_a;
  logic [W-1:0] out_data_a, kf_DATA_IN_a;
  logic [ADDRW-1:0] kf_DIR_a;
  logic in_ready_b, out_valid_b, out_timeout_b, kf_START_b, kf_WRITE_b, busy_b;
  logic [W-1:0] out_data_b, kf_DATA_IN_b;
  logic [ADDRW-1:0] kf_DIR_b;

  always #5 clk = ~clk;

  kf_host_ctrl #(.W(W), .ADDRW(ADDRW), .NLOAD(NLOAD), .LOAD_BASE(BASE_A), .TO_W(TO_W)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_timeout(out_timeout_a),
    .timeout_limit(timeout_limit), .kf_START(kf_START_a), .kf_DATA_IN(kf_DATA_IN_a), .kf_DIR(kf_DIR_a),
    .kf_WRITE(kf_WRITE_a), .kf_READY(kf_READY), .kf_DATA_OUT(kf_DATA_OUT), .busy(busy_a));

  kf_host_ctrl #(.W(W), .ADDRW(ADDRW), .NLOAD(NLOAD), .LOAD_BASE(BASE_B), .TO_W(TO_W)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_timeout(out_timeout_b),
    .timeout_limit(timeout_limit), .kf_START(kf_START_b), .kf_DATA_IN(kf_DATA_IN_b), .kf_DIR(kf_DIR_b),
    .kf_WRITE(kf_WRITE_b), .kf_READY(kf_READY), .kf_DATA_OUT(kf_DATA_OUT), .busy(busy_b));

  typedef struct {
    int               c;
    logic [ADDRW-1:0] dir;
    logic [W-1:0]     data;
  } wr_t;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int overlap = 0;
  wr_t wq_a[$], wq_b[$];
  int st_a[$], st_b[$], acc_cyc[$];
  logic [W-1:0] fw [NLOAD];

  always @(posedge clk) cyc <= cyc + 1;

  // Pin monitor: logs every write and start pulse with the cycle it was observed in.
  always @(negedge clk) begin
    wr_t w;
    if (kf_WRITE_a) begin w.c = cyc; w.dir = kf_DIR_a; w.data = kf_DATA_IN_a; wq_a.push_back(w); end
    if (kf_WRITE_b) begin w.c = cyc; w.dir = kf_DIR_b; w.data = kf_DATA_IN_b; wq_b.push_back(w); end
    if (kf_START_a) st_a.push_back(cyc);
    if (kf_START_b) st_b.push_back(cyc);
    if ((kf_START_a && kf_WRITE_a) || (kf_START_b && kf_WRITE_b)) overlap++;
  end

  task automatic clear_logs();
    wq_a.delete(); wq_b.delete(); st_a.delete(); st_b.delete(); acc_cyc.delete();
    overlap = 0;
  endtask

  task automatic load_words(input string tag, input int count, input int max_gap);
    int n;
    bit acc;
    for (int i = 0; i < count; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      in_valid = 1'b0;
      in_data  = W'($urandom);
      repeat (g) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = fw[i];
      n = 0;
      do begin
        @(negedge clk); acc = in_ready_a;
        @(posedge clk); #1; n++;
      end while (!acc && n < 30);
      acc_cyc.push_back(cyc);
      n_cmp++;
      if (!acc) begin
        n_err++;
        $display("FAIL %s accept[%0d]: in_ready got 0 after %0d cycles, required 1", tag, i, n);
      end
    end
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (st_a.size() == 0 && n < 30) begin @(negedge clk); n++; end
    n_cmp++;
    if (st_a.size() != 1 || st_b.size() != 1) begin
      n_err++;
      $display("FAIL %s start_count: got %0d/%0d pulses, required 1", tag, st_a.size(), st_b.size());
    end
  endtask

  task automatic check_writes(input string tag);
    n_cmp++;
    if (wq_a.size() != NLOAD || wq_b.size() != NLOAD) begin
      n_err++;
      $display("FAIL %s write_count: got %0d/%0d, required %0d", tag, wq_a.size(), wq_b.size(), NLOAD);
    end else begin
      for (int i = 0; i < NLOAD; i++) begin
        logic [ADDRW-1:0] ea, eb;
        ea = ADDRW'((BASE_A + i) % (1 << ADDRW));
        eb = ADDRW'((BASE_B + i) % (1 << ADDRW));
        n_cmp++;
        if (wq_a[i].dir !== ea || wq_b[i].dir !== eb) begin
          n_err++;
          $display("FAIL %s dir[%0d]: got %0d/%0d, required %0d/%0d", tag, i, wq_a[i].dir, wq_b[i].dir, ea, eb);
        end
        n_cmp++;
        if (wq_a[i].data !== fw[i] || wq_b[i].data !== fw[i]) begin
          n_err++;
          $display("FAIL %s data[%0d]: got %h/%h, required %h", tag, i, wq_a[i].data, wq_b[i].data, fw[i]);
        end
        n_cmp++;
        if (i < acc_cyc.size() && wq_a[i].c !== acc_cyc[i]) begin
          n_err++;
          $display("FAIL %s write_cycle[%0d]: got %0d, required %0d", tag, i, wq_a[i].c, acc_cyc[i]);
        end
      end
      n_cmp++;
      if (st_a.size() > 0 && st_a[0] !== wq_a[NLOAD-1].c + 1) begin
        n_err++;
        $display("FAIL %s start_cycle: got %0d, required %0d", tag, st_a[0], wq_a[NLOAD-1].c + 1);
      end
    end
    n_cmp++;
    if (overlap != 0) begin
      n_err++;
      $display("FAIL %s start_with_write: got %0d overlaps, required 0", tag, overlap);
    end
  endtask

  task automatic respond_and_drain(input string tag, input int pre_hold, input int busy_len,
                                   input int out_stall, input logic [W-1:0] res);
    @(posedge clk); #1;
    repeat (pre_hold) begin @(posedge clk); #1; end
    kf_READY = 1'b0;
    repeat (busy_len) begin @(posedge clk); #1; end
    n_cmp++;
    if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
      n_err++;
      $display("FAIL %s early_valid: got %b/%b, required 0", tag, out_valid_a, out_valid_b);
    end
    kf_READY = 1'b1;
    kf_DATA_OUT = res;
    @(posedge clk); #1;
    kf_DATA_OUT = W'($urandom);
    n_cmp++;
    if (out_valid_a !== 1'b1 || out_valid_b !== 1'b1 || out_data_a !== res || out_data_b !== res) begin
      n_err++;
      $display("FAIL %s result: got valid %b/%b data %h/%h, required 1 %h", tag,
               out_valid_a, out_valid_b, out_data_a, out_data_b, res);
    end
    n_cmp++;
    if (out_timeout_a !== 1'b0 || out_timeout_b !== 1'b0) begin
      n_err++;
      $display("FAIL %s timeout_flag: got %b/%b, required 0", tag, out_timeout_a, out_timeout_b);
    end
    if (out_stall > 0) begin
      out_ready = 1'b0;
      for (int s = 0; s < out_stall; s++) begin
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid_a !== 1'b1 || out_data_a !== res || out_data_b !== res) begin
          n_err++;
          $display("FAIL %s stall[%0d]: got valid %b data %h, required 1 %h", tag, s, out_valid_a, out_data_a, res);
        end
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
      n_err++;
      $display("FAIL %s handshake: got valid %b/%b busy %b/%b, required 0", tag,
               out_valid_a, out_valid_b, busy_a, busy_b);
    end
  endtask

  task automatic run_frame(input string tag, input int max_gap, input int pre_hold,
                           input int busy_len, input int out_stall, input logic [W-1:0] res);
    clear_logs();
    kf_READY = 1'b1;
    load_words(tag, NLOAD, max_gap);
    wait_start(tag);
    check_writes(tag);
    respond_and_drain(tag, pre_hold, busy_len, out_stall, res);
    $display("frame %s: %0d writes, result %h", tag, wq_a.size(), res);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if ({in_ready_a, out_valid_a, out_timeout_a, kf_START_a, kf_WRITE_a, busy_a} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b, required 000000",
               {in_ready_a, out_valid_a, out_timeout_a, kf_START_a, kf_WRITE_a, busy_a});
    end
    n_cmp++;
    if (out_data_a !== '0 || kf_DATA_IN_a !== '0 || kf_DIR_a !== '0 || kf_DIR_b !== '0) begin
      n_err++;
      $display("FAIL reset_data: got out %h din %h dir %0d/%0d, required 0", out_data_a, kf_DATA_IN_a, kf_DIR_a, kf_DIR_b);
    end
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++;
    if (in_ready_a !== 1'b0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL idle_wait: got in_ready %b busy %b with READY low, required 0 0", in_ready_a, busy_a);
    end
    $display("reset: checked");
  endtask

  task automatic test_load_defaults();
    fw[0] = 24'h000100; fw[1] = 24'h000200; fw[2] = 24'h000300; fw[3] = 24'h000400;
    run_frame("load_defaults", 0, 0, 10, 0, 24'h123456);
  endtask

  task automatic test_stalls();
    for (int i = 0; i < NLOAD; i++) fw[i] = W'($urandom);
    run_frame("stalls", 3, 1, int'($urandom_range(4, 1)), 5, W'($urandom));
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NLOAD; i++) fw[i] = W'($urandom);
      run_frame($sformatf("b2b%0d", f), int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
                int'($urandom_range(4, 1)), int'($urandom_range(3, 0)), W'($urandom));
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    for (int i = 0; i < NLOAD; i++) fw[i] = W'($urandom);
    clear_logs();
    kf_READY = 1'b1;
    kf_DATA_OUT = 24'hABCDEF;
`ifdef KF_HOST_TIMEOUT_EN
    timeout_limit = 16'd8;
    load_words("timeout", NLOAD, 0);
    wait_start("timeout");
    check_writes("timeout");
    do begin @(posedge clk); #1; n++; end while (!out_valid_a && n < 40);
    n_cmp++;
    if (n != 8) begin
      n_err++;
      $display("FAIL timeout_latency: got %0d cycles, required 8", n);
    end
    n_cmp++;
    if (out_timeout_a !== 1'b1 || out_data_a !== '0 || out_timeout_b !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_result: got flag %b data %h, required 1 000000", out_timeout_a, out_data_a);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid_a !== 1'b0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_handshake: got valid %b busy %b, required 0 0", out_valid_a, busy_a);
    end
    timeout_limit = '0;
    $display("timeout: fired after %0d cycles", n);
`else
    timeout_limit = 16'd8;
    load_words("no_timeout", NLOAD, 0);
    wait_start("no_timeout");
    check_writes("no_timeout");
    repeat (40) begin @(posedge clk); #1; end
    n_cmp++;
    if (out_valid_a !== 1'b0 || busy_a !== 1'b1 || out_timeout_a !== 1'b0) begin
      n_err++;
      $display("FAIL no_timeout_wait: got valid %b busy %b flag %b, required 0 1 0", out_valid_a, busy_a, out_timeout_a);
    end
    respond_and_drain("no_timeout", 0, 2, 0, W'($urandom));
    timeout_limit = '0;
    $display("timeout: disabled build waited %0d cycles", n + 40);
`endif
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < NLOAD; i++) fw[i] = W'($urandom);
    clear_logs();
    kf_READY = 1'b1;
    load_words("midframe", 2, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({kf_START_a, kf_WRITE_a, busy_a, in_ready_a, out_valid_a, kf_START_b, kf_WRITE_b, busy_b} !== 8'b0 ||
        kf_DATA_IN_a !== '0 || kf_DIR_a !== '0 || kf_DIR_b !== '0) begin
      n_err++;
      $display("FAIL midframe_reset: got start %b write %b busy %b dir %0d/%0d din %h, required all 0",
               kf_START_a, kf_WRITE_a, busy_a, kf_DIR_a, kf_DIR_b, kf_DATA_IN_a);
    end
    rst = 1'b0;
    fw[0] = 24'h000100; fw[1] = 24'h000200; fw[2] = 24'h000300; fw[3] = 24'h000400;
    run_frame("after_reset", 0, 0, 10, 0, 24'h123456);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    kf_READY = 1'b0; kf_DATA_OUT = '0; timeout_limit = '0;
    test_reset();
    test_load_defaults();
    test_stalls();
    test_back_to_back();
    test_timeout();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/kf_host_ctrl.md
# kf_host_ctrl

Host-side initiator for the Kalman filter ASIC external port. Accepts a frame of NLOAD measurement/state words on a valid/ready stream and writes them into the ASIC data bank at consecutive DIR addresses. It then pulses START, tracks READY through busy and back to idle, and returns the captured DATA_OUT word on a valid/ready output stream. It sits between the system bus/testbench and the filter core and drives the core's DATA_IN, DIR, WRITE and START pins.

## Interface
- W, 24: data width, equal to the filter datapath width
- ADDRW, 5: DIR width
- NLOAD, 4: words per frame, range 1..2^ADDRW
- LOAD_BASE, 0: DIR of the first frame word
- TO_W, 16: timeout counter width
- clk  in  1  system clock, single domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  frame word valid
- in_ready  out  1  frame word accepted when in_valid && in_ready
- in_data  in  W  frame word
- out_valid  out  1  result word valid
- out_ready  in  1  result consumer ready
- out_data  out  W  captured result
- out_timeout  out  1  qualifies out_data as a timeout; valid with out_valid
- timeout_limit  in  TO_W  maximum wait cycles; 0 disables the timeout
- kf_START  out  1  to filter START
- kf_DATA_IN  out  W  to filter DATA_IN
- kf_DIR  out  ADDRW  to filter DIR
- kf_WRITE  out  1  to filter WRITE
- kf_READY  in  1  from filter READY
- kf_DATA_OUT  in  W  from filter DATA_OUT
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, LOAD, KICK, WAIT_BUSY, WAIT_DONE, OUT.
- IDLE: in_ready=0. If kf_READY=1 is sampled, go to LOAD. idx=0.
- LOAD: in_ready=1 (combinational, equal to state==LOAD).
  - Each accepted word registers kf_WRITE=1, kf_DATA_IN=in_data, kf_DIR=LOAD_BASE+idx.
  - The kf_DIR sum wraps modulo 2^ADDRW. idx then increments.
  - On a cycle with no accept, kf_WRITE=0; kf_DATA_IN and kf_DIR hold.
  - The accept of word NLOAD-1 moves the FSM to KICK.
- KICK: one cycle. The last write is still on the pins. Next edge: kf_WRITE=0, kf_START=1, go to WAIT_BUSY.
- WAIT_BUSY: kf_START returns to 0 after one cycle. kf_READY=0 sampled → WAIT_DONE.
- WAIT_DONE: kf_READY=1 sampled → out_data<=kf_DATA_OUT, out_timeout<=0, out_valid<=1, go to OUT.
- OUT: out_valid held until out_valid && out_ready. The handshake edge clears out_valid and returns to IDLE. out_data and out_timeout are stable while out_valid=1.
- Timeout:
  - The counter clears on entry to WAIT_BUSY and increments each cycle in WAIT_BUSY and WAIT_DONE.
  - If the counter equals timeout_limit (≠0) and the exit condition is not met that cycle, go to OUT with out_data=0 and out_timeout=1.
  - The counter saturates at all-ones.
- Reset (any state, including mid-frame): next edge gives IDLE, idx=0, all kf_* outputs 0, out_valid=0, out_data=0, out_timeout=0.
- A partially loaded frame is abandoned on reset; the filter bank contents are not restored.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_timeout=0, kf_START=0, kf_WRITE=0, kf_DATA_IN=0, kf_DIR=0, busy=0.
- Write latency: the accept at edge k gives kf_WRITE high during cycle k..k+1. Back-to-back accepts give back-to-back writes, one per cycle.
- kf_START asserts exactly one cycle, on the cycle after the last kf_WRITE. It is never asserted together with kf_WRITE.
- Result latency: kf_READY=1 sampled at edge m in WAIT_DONE gives out_valid=1 from edge m. out_data equals kf_DATA_OUT at edge m.
- A READY glitch in WAIT_BUSY that stays high is not treated as completion. Only the 1→0→1 sequence completes the frame.
- Minimum frame turnaround is NLOAD+5 cycles, assuming a one-cycle filter busy and out_ready held high.

## Configuration
- KF_HOST_TIMEOUT_EN defined: the timeout counter and timeout_limit are active as described above.
- KF_HOST_TIMEOUT_EN undefined:
  - The counter is not built.
  - timeout_limit is ignored.
  - out_timeout is tied 0.
  - WAIT_BUSY and WAIT_DONE wait indefinitely.

## Test plan
- Load, defaults: kf_READY=1, stream 0x000100, 0x000200, 0x000300, 0x000400. Required: four kf_WRITE cycles at DIR 0..3 with those data, then one kf_START cycle. Model READY low for 10 cycles then high with DATA_OUT=0x123456. Required: out_valid with out_data=0x123456, out_timeout=0.
- Stalls: in_valid gaps between words and out_ready low for 5 cycles. Required: kf_WRITE only on accepted words; out_data held stable until the handshake.
- Wrap: LOAD_BASE=30, NLOAD=4. Required: DIR sequence 30, 31, 0, 1.
- Timeout (macro defined): timeout_limit=8, READY never falls. Required: out_valid with out_timeout=1, out_data=0, 8 cycles after entering WAIT_BUSY.
- Reset mid-frame: rst after 2 of 4 words. Required: next cycle all kf_* =0, busy=0. A following full frame behaves as in the first scenario with DIR starting at LOAD_BASE.
